sd_block_arbiter: RTL

SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

---
 rtl/sd_block_arbiter_if.sv | 38 +++
 rtl/sd_block_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sd_block_arbiter_if.sv
// Requester and SD-controller signal bundle for sd_block_arbiter.
// master = the arbiter; slave = requesters plus SD controller (or a bench driving both).
interface sd_block_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_op;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [7:0]  wr_byte0;
  logic [7:0]  wr_byte1;
  logic [1:0]  grant;
  logic [1:0]  byte_strobe;
  logic [7:0]  rd_byte;
  logic [1:0]  done;
  logic        err;
  logic [9:0]  byte_cnt;
  logic        sd_execute;
  logic        sd_op_code;
  logic [31:0] sd_block_address;
  logic [7:0]  sd_outgoing_byte;
  logic [7:0]  sd_incoming_byte;
  logic        sd_finished_byte;
  logic        sd_finished_block;
  logic        sd_busy;

  modport master (
    input  req, req_op, req_addr0, req_addr1, wr_byte0, wr_byte1,
    input  sd_incoming_byte, sd_finished_byte, sd_finished_block, sd_busy,
    output grant, byte_strobe, rd_byte, done, err, byte_cnt,
    output sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte
  );

  modport slave (
    output req, req_op, req_addr0, req_addr1, wr_byte0, wr_byte1,
    output sd_incoming_byte, sd_finished_byte, sd_finished_block, sd_busy,
    input  grant, byte_strobe, rd_byte, done, err, byte_cnt,
    input  sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte
  );
endinterface

// File: rtl/sd_block_arbiter.sv
// Two-requester round-robin arbiter for one SD block controller; sd_execute one cycle after a request is seen in IDLE.
// Define SD_ARB_WATCHDOG_EN to abort transfers idle for TIMEOUT_CYCLES (err pulses with done); otherwise waits forever.
module sd_block_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_block_arbiter_if.master   bus
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("sd_block_arbiter: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    XFER      = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t      state_q;
  logic        owner_q;
  logic        ptr_q;
  logic [1:0]  grant_q;
  logic [1:0]  byte_strobe_q;
  logic [1:0]  done_q;
  logic        err_q;
  logic        sd_execute_q;
  logic        sd_op_code_q;
  logic [31:0] addr_q;
  logic [7:0]  rd_byte_q;
  logic [9:0]  byte_cnt_q;

  logic        sel_d;
  logic [1:0]  owner_onehot_d;
  logic        wdog_hit_d;

  // Both requesting: pointer decides; otherwise the lone requester wins.
  always_comb begin
    sel_d = 1'b0;
    if (bus.req == 2'b11) sel_d = ptr_q;
    else                  sel_d = bus.req[1];
  end

  assign owner_onehot_d = owner_q ? 2'b10 : 2'b01;

`ifdef SD_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] wdog_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q == ISSUE || bus.sd_finished_byte) begin
      wdog_q <= '0;
    end else if (state_q == WAIT_BUSY || state_q == XFER) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign wdog_hit_d = (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_hit_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      ptr_q         <= 1'b0;
      grant_q       <= 2'b00;
      byte_strobe_q <= 2'b00;
      done_q        <= 2'b00;
      err_q         <= 1'b0;
      sd_execute_q  <= 1'b0;
      sd_op_code_q  <= 1'b0;
      addr_q        <= 32'h0;
      rd_byte_q     <= 8'h00;
      byte_cnt_q    <= 10'd0;
    end else begin
      sd_execute_q  <= 1'b0;
      byte_strobe_q <= 2'b00;
      done_q        <= 2'b00;
      err_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((|bus.req) && !bus.sd_busy) begin
            owner_q      <= sel_d;
            grant_q      <= sel_d ? 2'b10 : 2'b01;
            sd_op_code_q <= bus.req_op[sel_d];
            addr_q       <= sel_d ? bus.req_addr1 : bus.req_addr0;
            byte_cnt_q   <= 10'd0;
            sd_execute_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.sd_busy) begin
            state_q <= XFER;
          end else if (wdog_hit_d) begin
            done_q  <= owner_onehot_d;
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end
        end
        XFER: begin
          if (bus.sd_finished_byte) begin
            byte_strobe_q <= owner_onehot_d;
            rd_byte_q     <= bus.sd_incoming_byte;
            byte_cnt_q    <= byte_cnt_q + 10'd1;
          end
          // Block completion wins over a simultaneous timeout.
          if (bus.sd_finished_block) begin
            done_q  <= owner_onehot_d;
            state_q <= RELEASE;
          end else if (wdog_hit_d && !bus.sd_finished_byte) begin
            done_q  <= owner_onehot_d;
            err_q   <= 1'b1;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          grant_q <= 2'b00;
          ptr_q   <= ~owner_q;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= 2'b00;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant            = grant_q;
  assign bus.byte_strobe      = byte_strobe_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.rd_byte          = rd_byte_q;
  assign bus.byte_cnt         = byte_cnt_q;
  assign bus.sd_execute       = sd_execute_q;
  assign bus.sd_op_code       = sd_op_code_q;
  assign bus.sd_block_address = addr_q;
  assign bus.sd_outgoing_byte = grant_q[0] ? bus.wr_byte0 :
                                grant_q[1] ? bus.wr_byte1 : 8'h00;

endmodule
